// File: rtl/mar_access_arbiter.sv
// mar_access_arbiter: shares the MAR and the memory port between instruction
// fetch and data load/store. One transaction runs at a time through
// IDLE -> LOAD -> ACCESS -> RESP, and all outputs are registered.
// Optional build macro ROUND_ROBIN_EN: when it is defined, simultaneous
// requests alternate between the two requesters. When it is undefined, data
// has fixed priority over fetch.
module mar_access_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mar_load,
    output logic [ADDR_WIDTH-1:0] mar_address_in,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_gnt_data;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_any_req;
    logic                  w_pick_data;
    logic                  w_last_access;

    logic                  w_fetch_ack;
    logic [DATA_WIDTH-1:0] w_fetch_rdata;
    logic                  w_data_ack;
    logic [DATA_WIDTH-1:0] w_data_rdata;
    logic                  w_mar_load;
    logic [ADDR_WIDTH-1:0] w_mar_address_in;
    logic                  w_mem_rd;
    logic                  w_mem_wr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_busy;

    assign w_any_req     = fetch_req | data_req;
    assign w_last_access = (r_state == S_ACCESS) && (r_cnt == '0);

`ifdef ROUND_ROBIN_EN
    logic r_last_data;

    // On a tie, the requester that was not granted last wins.
    assign w_pick_data = data_req && (!fetch_req || !r_last_data);

    // Last-granted flag; it changes only when a grant is made.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_data <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_data <= w_pick_data;
        end
    end
`else
    // Fixed priority: data always beats fetch.
    assign w_pick_data = data_req;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the next state.
    always_comb begin
        w_busy           = (w_next_state != S_IDLE);
        w_mar_load       = 1'b0;
        w_mar_address_in = '0;
        w_mem_rd         = 1'b0;
        w_mem_wr         = 1'b0;
        w_mem_wdata      = '0;
        w_fetch_ack      = 1'b0;
        w_fetch_rdata    = '0;
        w_data_ack       = 1'b0;
        w_data_rdata     = '0;
        // LOAD is entered only from IDLE, so take the address straight from the winner.
        if (w_next_state == S_LOAD) begin
            w_mar_load       = 1'b1;
            w_mar_address_in = w_pick_data ? data_addr : fetch_addr;
        end
        if (w_next_state == S_ACCESS) begin
            w_mem_rd    = !r_we;
            w_mem_wr    = r_we;
            w_mem_wdata = r_wdata;
        end
        // Read data is captured on the edge that closes the final ACCESS cycle.
        if (w_last_access) begin
            if (r_gnt_data) begin
                w_data_ack   = 1'b1;
                w_data_rdata = r_we ? '0 : mem_rdata;
            end else begin
                w_fetch_ack   = 1'b1;
                w_fetch_rdata = mem_rdata;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy           <= 1'b0;
            mar_load       <= 1'b0;
            mar_address_in <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_wdata      <= '0;
            fetch_ack      <= 1'b0;
            fetch_rdata    <= '0;
            data_ack       <= 1'b0;
            data_rdata     <= '0;
        end else begin
            busy           <= w_busy;
            mar_load       <= w_mar_load;
            mar_address_in <= w_mar_address_in;
            mem_rd         <= w_mem_rd;
            mem_wr         <= w_mem_wr;
            mem_wdata      <= w_mem_wdata;
            fetch_ack      <= w_fetch_ack;
            fetch_rdata    <= w_fetch_rdata;
            data_ack       <= w_data_ack;
            data_rdata     <= w_data_rdata;
        end
    end

    // Latch the grant and its request attributes when leaving IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_data <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_gnt_data <= w_pick_data;
            r_we       <= w_pick_data && data_we;
            r_addr     <= w_pick_data ? data_addr : fetch_addr;
            r_wdata    <= (w_pick_data && data_we) ? data_wdata : '0;
        end
    end

    // Access-length down-counter; it is loaded as ACCESS begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= CNT_W'(MEM_LATENCY - 1);
        end else if (r_state == S_ACCESS && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Debug visibility of the latched address (mirrors what was sent to the MAR).
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    assign w_cur_addr = r_addr;

endmodule

// File: tb/tb_mar_access_arbiter.sv
// tb_mar_access_arbiter: directed test of mar_access_arbiter.
// Three instances (MEM_LATENCY 1, 3 and 4) share the same inputs. Each test
// starts from reset and checks only the instance whose latency it targets.
// Expectations for simultaneous requests follow ROUND_ROBIN_EN when it is defined.
module tb_mar_access_arbiter;

    logic       clk;
    logic       reset;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       data_req;
    logic       data_we;
    logic [7:0] data_addr;
    logic [7:0] data_wdata;
    logic [7:0] mem_rdata;

    logic       f_ack1, d_ack1, mload1, mrd1, mwr1, busy1;
    logic [7:0] f_rd1, d_rd1, maddr1, mwd1;
    logic       f_ack3, d_ack3, mload3, mrd3, mwr3, busy3;
    logic [7:0] f_rd3, d_rd3, maddr3, mwd3;
    logic       f_ack4, d_ack4, mload4, mrd4, mwr4, busy4;
    logic [7:0] f_rd4, d_rd4, maddr4, mwd4;

    int n_assert = 0;
    int n_fail   = 0;
    int n_busy   = 0;
    int n_rd     = 0;

    mar_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(f_ack1), .fetch_rdata(f_rd1),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(d_ack1), .data_rdata(d_rd1),
        .mar_load(mload1), .mar_address_in(maddr1), .mem_rd(mrd1), .mem_wr(mwr1),
        .mem_wdata(mwd1), .mem_rdata(mem_rdata), .busy(busy1)
    );

    mar_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(f_ack3), .fetch_rdata(f_rd3),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(d_ack3), .data_rdata(d_rd3),
        .mar_load(mload3), .mar_address_in(maddr3), .mem_rd(mrd3), .mem_wr(mwr3),
        .mem_wdata(mwd3), .mem_rdata(mem_rdata), .busy(busy3)
    );

    mar_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(f_ack4), .fetch_rdata(f_rd4),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(d_ack4), .data_rdata(d_rd4),
        .mar_load(mload4), .mar_address_in(maddr4), .mem_rd(mrd4), .mem_wr(mwr4),
        .mem_wdata(mwd4), .mem_rdata(mem_rdata), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_mar_load", 32'(mload1), 32'd0);
        chk("rst_mar_addr", 32'(maddr1), 32'd0);
        chk("rst_mem_rd", 32'(mrd1), 32'd0);
        chk("rst_mem_wr", 32'(mwr1), 32'd0);
        chk("rst_acks", 32'({f_ack1, d_ack1}), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(busy1), 32'd0);

        // Single fetch, latency 1
        fetch_req = 1'b1; fetch_addr = 8'hAB; mem_rdata = 8'h3C;
        tick();
        chk("f_load_strobe", 32'(mload1), 32'd1);
        chk("f_load_addr", 32'(maddr1), 32'hAB);
        chk("f_load_busy", 32'(busy1), 32'd1);
        chk("f_load_rd", 32'(mrd1), 32'd0);
        tick();
        chk("f_acc_rd", 32'(mrd1), 32'd1);
        chk("f_acc_wr", 32'(mwr1), 32'd0);
        chk("f_acc_load", 32'(mload1), 32'd0);
        chk("f_acc_addr", 32'(maddr1), 32'd0);
        chk("f_acc_ack", 32'(f_ack1), 32'd0);
        tick();
        chk("f_ack", 32'(f_ack1), 32'd1);
        chk("f_rdata", 32'(f_rd1), 32'h3C);
        chk("f_resp_rd", 32'(mrd1), 32'd0);
        chk("f_resp_dack", 32'(d_ack1), 32'd0);
        fetch_req = 1'b0;
        tick();
        chk("f_idle_ack", 32'(f_ack1), 32'd0);
        chk("f_idle_rdata", 32'(f_rd1), 32'd0);
        chk("f_idle_busy", 32'(busy1), 32'd0);

        // Data write
        do_reset();
        data_req = 1'b1; data_we = 1'b1; data_addr = 8'h78; data_wdata = 8'h5A; mem_rdata = 8'hEE;
        tick();
        chk("w_load_addr", 32'(maddr1), 32'h78);
        chk("w_load_strobe", 32'(mload1), 32'd1);
        tick();
        chk("w_acc_wr", 32'(mwr1), 32'd1);
        chk("w_acc_rd", 32'(mrd1), 32'd0);
        chk("w_acc_wdata", 32'(mwd1), 32'h5A);
        tick();
        chk("w_ack", 32'(d_ack1), 32'd1);
        chk("w_rdata", 32'(d_rd1), 32'd0);
        chk("w_resp_wr", 32'(mwr1), 32'd0);
        chk("w_resp_wdata", 32'(mwd1), 32'd0);
        data_req = 1'b0; data_we = 1'b0;
        tick();
        chk("w_idle_ack", 32'(d_ack1), 32'd0);

        // Simultaneous requests
        do_reset();
        fetch_req = 1'b1; fetch_addr = 8'h11;
        data_req = 1'b1; data_we = 1'b0; data_addr = 8'h22; mem_rdata = 8'h66;
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_load_addr", 32'(maddr1), (k % 2 == 0) ? 32'h11 : 32'h22);
            tick();
            tick();
            chk("rr_fetch_ack", 32'(f_ack1), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_data_ack", 32'(d_ack1), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 3) begin
                fetch_req = 1'b0; data_req = 1'b0;
            end
            tick();
        end
`else
        tick();
        chk("pr_load_addr0", 32'(maddr1), 32'h22);
        tick();
        tick();
        chk("pr_data_ack", 32'(d_ack1), 32'd1);
        chk("pr_data_rdata", 32'(d_rd1), 32'h66);
        chk("pr_fetch_ack0", 32'(f_ack1), 32'd0);
        data_req = 1'b0;
        tick();
        tick();
        chk("pr_load_addr1", 32'(maddr1), 32'h11);
        tick();
        chk("pr_fetch_early", 32'(f_ack1), 32'd0);
        tick();
        chk("pr_fetch_ack", 32'(f_ack1), 32'd1);
        chk("pr_fetch_rdata", 32'(f_rd1), 32'h66);
        fetch_req = 1'b0;
        tick();
`endif

        // Reset during ACCESS, latency 3
        do_reset();
        fetch_req = 1'b1; fetch_addr = 8'h33; mem_rdata = 8'h55;
        tick();
        tick();
        chk("ra_acc_rd", 32'(mrd3), 32'd1);
        reset = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("ra_rst_rd", 32'(mrd3), 32'd0);
        chk("ra_rst_busy", 32'(busy3), 32'd0);
        chk("ra_rst_outs", 32'({mload3, mwr3, f_ack3, d_ack3}), 32'd0);
        tick();
        tick();
        tick();
        chk("ra_no_ack", 32'(f_ack3), 32'd0);
        reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = 8'h10; mem_rdata = 8'h7E;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) begin
                chk("ra_load_addr", 32'(maddr3), 32'h10);
                fetch_req = 1'b0;
            end
            if (i == 4) chk("ra_ack_early", 32'(f_ack3), 32'd0);
            if (i == 5) begin
                chk("ra_ack", 32'(f_ack3), 32'd1);
                chk("ra_rdata", 32'(f_rd3), 32'h7E);
            end
            if (i == 6) chk("ra_ack_done", 32'(f_ack3), 32'd0);
        end

        // Latency 4 read; the request is dropped after the sample and is still completed
        do_reset();
        fetch_req = 1'b1; fetch_addr = 8'h44; mem_rdata = 8'h9D;
        n_busy = 0;
        n_rd = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) fetch_req = 1'b0;
            if (busy4) n_busy++;
            if (mrd4) n_rd++;
            if (i == 5) chk("l4_ack_early", 32'(f_ack4), 32'd0);
            if (i == 6) begin
                chk("l4_ack", 32'(f_ack4), 32'd1);
                chk("l4_rdata", 32'(f_rd4), 32'h9D);
            end
        end
        chk("l4_busy_cycles", 32'(n_busy), 32'd6);
        chk("l4_rd_cycles", 32'(n_rd), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
